// File: rtl/red_pitaya_asg_seq_pkg.sv
// Shared types for the ASG segment sequencer: FSM state, segment table entry
// and the channel-response watchdog length.
package red_pitaya_asg_seq_pkg;

    // Pointer fields are stored 32 bits wide; the sequencer uses the low RSZ+16 bits.
    localparam int unsigned SEG_PTR_W = 32;
    localparam logic [3:0]  WDOG_LEN  = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TRIG,
        S_WAIT_HI,
        S_WAIT_LO,
        S_GAP
    } asg_seq_state_t;

    typedef struct packed {
        logic [SEG_PTR_W-1:0] ofs;
        logic [SEG_PTR_W-1:0] size;
        logic [31:0]          step;
        logic [15:0]          ncyc;
        logic [7:0]           rep;
        logic [15:0]          gap;
    } seg_t;

endpackage

// File: rtl/red_pitaya_asg_seq.sv
// Segment sequencer for one ASG channel: plays a table of waveform segments by
// reprogramming the channel window, pulsing its reset and issuing sw triggers.
module red_pitaya_asg_seq
    import red_pitaya_asg_seq_pkg::*;
#(
    parameter int unsigned RSZ  = 14,
    parameter int unsigned NSEG = 8
)(
    input  logic                    dac_clk_i,
    input  logic                    dac_rst_i,
    input  logic                    start_i,
    input  logic                    stop_i,
    input  logic                    loop_i,
    input  logic [$clog2(NSEG):0]   seq_len_i,
    input  logic                    seg_we_i,
    input  logic [$clog2(NSEG)-1:0] seg_addr_i,
    input  logic [RSZ+15:0]         seg_ofs_i,
    input  logic [RSZ+15:0]         seg_size_i,
    input  logic [31:0]             seg_step_i,
    input  logic [15:0]             seg_ncyc_i,
    input  logic [7:0]              seg_rep_i,
    input  logic [15:0]             seg_gap_i,
    input  logic                    ch_active_i,
    output logic [RSZ+15:0]         set_ofs_o,
    output logic [RSZ+15:0]         set_size_o,
    output logic [31:0]             set_step_o,
    output logic [15:0]             set_ncyc_o,
    output logic                    set_rst_o,
    output logic                    trig_sw_o,
    output logic [$clog2(NSEG)-1:0] seq_idx_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    localparam int unsigned IW = $clog2(NSEG);
    localparam int unsigned LW = IW + 1;
    localparam int unsigned PW = RSZ + 16;

    seg_t tbl [NSEG];
    seg_t rd;

    asg_seq_state_t  state_q, state_d;
    logic [IW-1:0]   idx_d;
    logic [7:0]      rep_q, rep_d;
    logic [15:0]     gap_q, gap_d;
    logic [3:0]      wdog_q, wdog_d;
    logic [PW-1:0]   ofs_d, size_d;
    logic [31:0]     step_d;
    logic [15:0]     ncyc_d;
    logic            rst_d, trig_d, busy_d, done_d, err_d;
    logic [LW-1:0]   len_eff;
    logic            is_last;

    always_ff @(posedge dac_clk_i) begin
        if (seg_we_i) begin
            tbl[seg_addr_i] <= '{ofs:  SEG_PTR_W'(seg_ofs_i),
                                 size: SEG_PTR_W'(seg_size_i),
                                 step: seg_step_i,
                                 ncyc: seg_ncyc_i,
                                 rep:  seg_rep_i,
                                 gap:  seg_gap_i};
        end
    end

    always_comb begin
        if (seq_len_i == '0) begin
            len_eff = LW'(1);
        end else if (seq_len_i > LW'(NSEG)) begin
            len_eff = LW'(NSEG);
        end else begin
            len_eff = seq_len_i;
        end
    end

    assign is_last = (LW'(seq_idx_o) + LW'(1)) >= len_eff;

    // Outputs are registered from the next state, so each output value is
    // visible during the cycle the FSM occupies the state that produces it.
    always_comb begin
        state_d = state_q;
        idx_d   = seq_idx_o;
        rep_d   = rep_q;
        gap_d   = gap_q;
        wdog_d  = wdog_q;
        ofs_d   = set_ofs_o;
        size_d  = set_size_o;
        step_d  = set_step_o;
        ncyc_d  = set_ncyc_o;
        rst_d   = 1'b0;
        trig_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = err_o;

        if (stop_i && state_q != S_IDLE) begin
            state_d = S_IDLE;
            rst_d   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        idx_d   = '0;
                        err_d   = 1'b0;
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    trig_d  = 1'b1;
                    state_d = S_TRIG;
                end
                S_TRIG: begin
                    wdog_d  = WDOG_LEN;
                    state_d = S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (ch_active_i) begin
                        state_d = S_WAIT_LO;
                    end else if (wdog_q == '0) begin
                        err_d   = 1'b1;
                        rst_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        wdog_d = wdog_q - 4'd1;
                    end
                end
                S_WAIT_LO: begin
                    if (!ch_active_i) begin
                        if (rep_q != '0) begin
                            rep_d   = rep_q - 8'd1;
                            trig_d  = 1'b1;
                            state_d = S_TRIG;
                        end else begin
                            state_d = S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q != '0) begin
                        gap_d = gap_q - 16'd1;
                    end else if (!is_last) begin
                        idx_d   = seq_idx_o + IW'(1);
                        state_d = S_LOAD;
                    end else if (loop_i) begin
                        idx_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // The table register is read before this edge's write lands, so a
        // concurrent write to the entry being loaded yields the old contents.
        rd = tbl[idx_d];
        if (state_d == S_LOAD) begin
            ofs_d  = rd.ofs[PW-1:0];
            size_d = rd.size[PW-1:0];
            step_d = rd.step;
            ncyc_d = rd.ncyc;
            rep_d  = rd.rep;
            gap_d  = rd.gap;
            rst_d  = 1'b1;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            state_q    <= S_IDLE;
            seq_idx_o  <= '0;
            rep_q      <= '0;
            gap_q      <= '0;
            wdog_q     <= '0;
            set_ofs_o  <= '0;
            set_size_o <= '0;
            set_step_o <= '0;
            set_ncyc_o <= '0;
            set_rst_o  <= 1'b0;
            trig_sw_o  <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            state_q    <= state_d;
            seq_idx_o  <= idx_d;
            rep_q      <= rep_d;
            gap_q      <= gap_d;
            wdog_q     <= wdog_d;
            set_ofs_o  <= ofs_d;
            set_size_o <= size_d;
            set_step_o <= step_d;
            set_ncyc_o <= ncyc_d;
            set_rst_o  <= rst_d;
            trig_sw_o  <= trig_d;
            busy_o     <= busy_d;
            done_o     <= done_d;
            err_o      <= err_d;
        end
    end

    if (PW < SEG_PTR_W) begin : g_ptr_hi
        logic [2*(SEG_PTR_W-PW)-1:0] unused_ptr_hi;
        assign unused_ptr_hi = {rd.ofs[SEG_PTR_W-1:PW], rd.size[SEG_PTR_W-1:PW]};
    end

endmodule

// File: tb/tb_red_pitaya_asg_seq.sv
// Bench for red_pitaya_asg_seq: a sequential reference model of the segment
// player checked every cycle, plus directed scenarios with literal expectations.
module tb_red_pitaya_asg_seq;

    localparam int RSZ  = 14;
    localparam int NSEG = 8;
    localparam int IW   = 3;
    localparam int LW   = 4;
    localparam int PW   = RSZ + 16;

    logic          clk = 1'b0;
    logic          dac_rst = 1'b1, start = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [LW-1:0] seq_len = '0;
    logic          we = 1'b0;
    logic [IW-1:0] waddr = '0;
    logic [PW-1:0] wofs = '0, wsize = '0;
    logic [31:0]   wstep = '0;
    logic [15:0]   wncyc = '0, wgap = '0;
    logic [7:0]    wrep = '0;
    logic          ch_active = 1'b0;

    logic [PW-1:0] set_ofs_o, set_size_o;
    logic [31:0]   set_step_o;
    logic [15:0]   set_ncyc_o;
    logic          set_rst_o, trig_sw_o, busy_o, done_o, err_o;
    logic [IW-1:0] seq_idx_o;

    always #5 clk = ~clk;

    red_pitaya_asg_seq #(.RSZ(RSZ), .NSEG(NSEG)) dut (
        .dac_clk_i(clk), .dac_rst_i(dac_rst), .start_i(start), .stop_i(stop),
        .loop_i(loop_en), .seq_len_i(seq_len), .seg_we_i(we), .seg_addr_i(waddr),
        .seg_ofs_i(wofs), .seg_size_i(wsize), .seg_step_i(wstep), .seg_ncyc_i(wncyc),
        .seg_rep_i(wrep), .seg_gap_i(wgap), .ch_active_i(ch_active),
        .set_ofs_o(set_ofs_o), .set_size_o(set_size_o), .set_step_o(set_step_o),
        .set_ncyc_o(set_ncyc_o), .set_rst_o(set_rst_o), .trig_sw_o(trig_sw_o),
        .seq_idx_o(seq_idx_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    int n_pass = 0, n_chk = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [PW-1:0] ofs, size;
        logic [31:0]   step;
        logic [15:0]   ncyc;
        logic [7:0]    rep;
        logic [15:0]   gap;
    } mseg_t;

    mseg_t m_tbl [NSEG];
    always @(posedge clk) if (we) m_tbl[waddr] <= '{wofs, wsize, wstep, wncyc, wrep, wgap};

    logic [PW-1:0] e_ofs = '0, e_size = '0;
    logic [31:0]   e_step = '0;
    logic [15:0]   e_ncyc = '0;
    logic [IW-1:0] e_idx = '0;
    logic          e_rst = 0, e_trig = 0, e_busy = 0, e_done = 0, e_err = 0;
    bit            m_abort;

    // One clock of the player: pulses fall, then reset / stop pre-empt everything.
    task automatic m_step();
        @(posedge clk);
        e_rst = 0; e_trig = 0; e_done = 0; m_abort = 0;
        if (dac_rst) begin
            e_ofs = '0; e_size = '0; e_step = '0; e_ncyc = '0; e_idx = '0;
            e_busy = 0; e_err = 0; m_abort = 1;
        end else if (stop && e_busy) begin
            e_rst = 1; e_busy = 0; m_abort = 1;
        end
    endtask

    task automatic m_run();
        int    idx = 0;
        int    len;
        mseg_t s;
        bit    got;
        forever begin
            s = m_tbl[idx];
            e_idx = IW'(idx);
            e_ofs = s.ofs; e_size = s.size; e_step = s.step; e_ncyc = s.ncyc;
            e_rst = 1; e_busy = 1;
            m_step(); if (m_abort) return;
            for (int r = 0; r <= int'(s.rep); r++) begin
                e_trig = 1;
                m_step(); if (m_abort) return;
                got = 0;
                for (int w = 0; w < 16 && !got; w++) begin
                    m_step(); if (m_abort) return;
                    got = ch_active;
                end
                if (!got) begin
                    e_err = 1; e_rst = 1; e_busy = 0;
                    return;
                end
                do begin
                    m_step(); if (m_abort) return;
                end while (ch_active);
            end
            for (int g = 0; g <= int'(s.gap); g++) begin
                m_step(); if (m_abort) return;
            end
            len = (seq_len == 0) ? 1 : ((int'(seq_len) > NSEG) ? NSEG : int'(seq_len));
            if (idx + 1 < len) idx++;
            else if (loop_en) idx = 0;
            else begin
                e_done = 1; e_busy = 0;
                return;
            end
        end
    endtask

    initial begin
        forever begin
            m_step();
            if (!m_abort && start) begin
                e_err = 0;
                m_run();
            end
        end
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("ofs",  set_ofs_o,  e_ofs);
            check("size", set_size_o, e_size);
            check("step", set_step_o, e_step);
            check("ncyc", set_ncyc_o, e_ncyc);
            check("rst",  set_rst_o,  e_rst);
            check("trig", trig_sw_o,  e_trig);
            check("idx",  seq_idx_o,  e_idx);
            check("busy", busy_o,     e_busy);
            check("done", done_o,     e_done);
            check("err",  err_o,      e_err);
        end
    end

    // ---------------- channel model and pulse counters ----------------
    bit chan_en = 1;
    int ch_t = -1;
    always @(negedge clk) begin
        if (trig_sw_o && chan_en) ch_t = 0;
        else if (ch_t >= 0 && ch_t < 12) ch_t++;
        else ch_t = -1;
        ch_active = (ch_t >= 2 && ch_t < 12);
    end

    int c_trig = 0, c_rst = 0, c_done = 0, c_load = 0;
    int idx_hist[$];
    always @(negedge clk) begin
        if (trig_sw_o) c_trig++;
        if (set_rst_o) c_rst++;
        if (done_o)    c_done++;
        if (set_rst_o && busy_o) begin
            c_load++;
            idx_hist.push_back(int'(seq_idx_o));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        @(posedge clk); #1;
        c_trig = 0; c_rst = 0; c_done = 0; c_load = 0;
        idx_hist.delete();
    endtask

    task automatic wr(input int a, input int ofs, input int rep, input int gap);
        @(negedge clk);
        we = 1; waddr = IW'(a); wofs = PW'(ofs); wsize = PW'(1000 + a);
        wstep = 32'(a + 1); wncyc = 16'(a + 2); wrep = 8'(rep); wgap = 16'(gap);
        @(negedge clk);
        we = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
    endtask

    task automatic pulse_stop();
        @(negedge clk); stop = 1;
        @(negedge clk); stop = 0;
    endtask

    task automatic wait_idle(input int max, input string tag);
        int k = 0;
        while (busy_o && k < max) begin @(negedge clk); k++; end
        check({tag, "_idle_timeout"}, busy_o, 0);
    endtask

    task automatic wait_load(input int idx, input int max, input string tag);
        int k = 0;
        while (!(set_rst_o && busy_o && int'(seq_idx_o) == idx) && k < max) begin
            @(negedge clk); k++;
        end
        check({tag, "_load_timeout"}, (k < max), 1);
    endtask

    task automatic wait_ch(input logic lvl, input int max, input string tag);
        int k = 0;
        while (ch_active !== lvl && k < max) begin @(negedge clk); k++; end
        check({tag, "_ch_timeout"}, (k < max), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "global timeout");
    end

    initial begin
        cyc(3);
        dac_rst = 0;
        chk_en = 1;
        check("reset_busy", busy_o, 0);
        check("reset_ofs", set_ofs_o, 0);
        check("reset_err", err_o, 0);
        for (int a = 0; a < NSEG; a++) wr(a, 100 * a + 5, 0, 0);

        // Two segments, second one retriggered once.
        wr(0, 5, 0, 3);
        wr(1, 105, 1, 0);
        seq_len = 2; loop_en = 0;
        clear_counts();
        pulse_start();
        check("t1_first_ofs", set_ofs_o, 5);
        check("t1_first_rst", set_rst_o, 1);
        wait_idle(400, "t1");
        cyc(2);
        check("t1_trig_cnt", c_trig, 3);
        check("t1_rst_cnt", c_rst, 2);
        check("t1_done_cnt", c_done, 1);
        check("t1_err", err_o, 0);

        // Silent channel: watchdog error.
        chan_en = 0; seq_len = 1;
        clear_counts();
        pulse_start();
        wait_idle(100, "t2");
        cyc(2);
        check("t2_err", err_o, 1);
        check("t2_done_cnt", c_done, 0);
        check("t2_rst_cnt", c_rst, 2);
        check("t2_trig_cnt", c_trig, 1);
        chan_en = 1;

        // Looping over three segments, then abort while the channel plays.
        wr(0, 5, 0, 0);
        wr(1, 105, 0, 0);
        seq_len = 3; loop_en = 1;
        clear_counts();
        pulse_start();
        check("t3_err_cleared", err_o, 0);
        begin
            int k = 0;
            while (c_load < 4 && k < 400) begin @(negedge clk); k++; end
        end
        check("t3_nload", c_load, 4);
        wait_ch(1'b1, 50, "t3");
        cyc(3);
        pulse_stop();
        check("t3_stop_rst", set_rst_o, 1);
        check("t3_stop_busy", busy_o, 0);
        check("t3_stop_done", done_o, 0);
        for (int i = 0; i < 4; i++) begin
            int exp_idx[4] = '{0, 1, 2, 0};
            check($sformatf("t3_idx_seq%0d", i), (idx_hist.size() > i) ? idx_hist[i] : -1, exp_idx[i]);
        end
        check("t3_done_cnt", c_done, 0);

        // Table write colliding with LOAD of the same entry.
        seq_len = 2; loop_en = 1;
        clear_counts();
        pulse_start();
        wait_load(1, 200, "t4a");
        check("t4_old_ofs", set_ofs_o, 105);
        we = 1; waddr = 3'd1; wofs = PW'(777); wsize = PW'(1001);
        wstep = 32'd2; wncyc = 16'd3; wrep = 8'd0; wgap = 16'd0;
        @(negedge clk);
        we = 0;
        wait_load(1, 200, "t4b");
        check("t4_new_ofs", set_ofs_o, 777);
        pulse_stop();
        wait_idle(10, "t4");

        // Sequence length boundaries.
        loop_en = 0; seq_len = 0;
        clear_counts();
        pulse_start();
        wait_idle(200, "t5a");
        cyc(1);
        check("t5_len0_loads", c_load, 1);
        check("t5_len0_done", c_done, 1);
        seq_len = 4'(NSEG + 3);
        clear_counts();
        pulse_start();
        wait_idle(1000, "t5b");
        cyc(1);
        check("t5_clamp_loads", c_load, NSEG);
        check("t5_clamp_done", c_done, 1);

        // Reset in the middle of a gap, then a normal restart.
        wr(0, 5, 0, 20);
        seq_len = 1;
        pulse_start();
        wait_ch(1'b1, 50, "t6a");
        wait_ch(1'b0, 50, "t6b");
        cyc(3);
        @(negedge clk); dac_rst = 1;
        @(negedge clk); dac_rst = 0;
        check("t6_busy", busy_o, 0);
        check("t6_ofs", set_ofs_o, 0);
        check("t6_size", set_size_o, 0);
        check("t6_step", set_step_o, 0);
        check("t6_rst", set_rst_o, 0);
        check("t6_done", done_o, 0);
        clear_counts();
        pulse_start();
        check("t6_restart_busy", busy_o, 1);
        check("t6_restart_rst", set_rst_o, 1);
        check("t6_restart_ofs", set_ofs_o, 5);
        wait_idle(200, "t6");
        cyc(1);
        check("t6_done_cnt", c_done, 1);

        cyc(2);
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/red_pitaya_asg_seq.md
# red_pitaya_asg_seq

Segment sequencer for one ASG channel. It holds a table of up to NSEG waveform segments; each segment has an offset, size, step, cycle count, repeat count and gap. It plays them in order by programming the channel's table-window configuration, pulsing the channel reset and issuing software triggers. It sits between the register bank and one ASG channel, owns that channel's ofs/size/step/ncyc/rst/sw-trigger inputs, and watches the channel's read-active flag.

## Interface
Parameters:
- RSZ, 14, channel buffer address width
- NSEG, 8, segment table depth (power of 2, ≥2)

Ports:
- dac_clk_i  in  1  DAC clock; the only clock
- dac_rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  start pulse; honoured in IDLE only
- stop_i  in  1  abort pulse; honoured in any state
- loop_i  in  1  after the last segment, restart at segment 0
- seq_len_i  in  $clog2(NSEG)+1  number of segments to play; 0 is treated as 1, values >NSEG are clamped to NSEG
- seg_we_i  in  1  table write enable
- seg_addr_i  in  $clog2(NSEG)  table write address
- seg_ofs_i  in  RSZ+16  segment start pointer
- seg_size_i  in  RSZ+16  segment size
- seg_step_i  in  32  segment pointer step
- seg_ncyc_i  in  16  buffer cycles per trigger
- seg_rep_i  in  8  extra triggers per segment (0 = play once)
- seg_gap_i  in  16  idle dac_clk cycles after the segment
- ch_active_i  in  1  channel read-active flag (the channel's dac_do)
- set_ofs_o  out  RSZ+16  to channel
- set_size_o  out  RSZ+16  to channel
- set_step_o  out  32  to channel
- set_ncyc_o  out  16  to channel
- set_rst_o  out  1  one-cycle channel reset pulse
- trig_sw_o  out  1  one-cycle software trigger pulse
- seq_idx_o  out  $clog2(NSEG)  current segment index
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse when the sequence ends normally
- err_o  out  1  sticky no-response error; cleared by an accepted start_i

## Operation
- All outputs are registered. On reset, every output is 0 and the FSM is in IDLE.
- The table is NSEG entries of {ofs, size, step, ncyc, rep, gap}. It is written whenever seg_we_i is high, in any state. Contents are undefined after reset.
- FSM states: IDLE, LOAD, TRIG, WAIT_HI, WAIT_LO, GAP.
- IDLE, start_i=1: idx←0, err_o←0, go to LOAD.
- LOAD: latch table[idx] into set_* and into the internal rep_cnt/gap_cnt; set_rst_o=1; go to TRIG.
- TRIG: trig_sw_o=1; load watchdog←15; go to WAIT_HI.
- WAIT_HI, ch_active_i=1: go to WAIT_LO.
- WAIT_HI, otherwise: decrement watchdog. When watchdog reaches 0: err_o←1, set_rst_o pulse, go to IDLE (done_o not asserted).
- WAIT_LO, ch_active_i=0, rep_cnt≠0: rep_cnt−1, go to TRIG (no reload, no reset).
- WAIT_LO, ch_active_i=0, rep_cnt=0: go to GAP.
- GAP: count gap_cnt down to 0 (gap=0 means one cycle in GAP). Then:
  - if idx<len−1: idx+1, go to LOAD;
  - else if loop_i: idx←0, go to LOAD;
  - else: done_o pulse, go to IDLE.
- stop_i in any non-IDLE state: set_rst_o pulse, go to IDLE (no done_o). stop_i takes priority over every other transition in the same cycle.
- stop_i in IDLE, or start_i while busy: ignored.
- A write to table[idx] in the same cycle LOAD reads that entry: LOAD takes the old contents. Writes to the current entry after LOAD take effect only on the next LOAD of that entry.
- set_* outputs hold their last loaded values in IDLE.

## Timing
- start_i sampled at cycle t → set_* valid and set_rst_o=1 at t+1 → trig_sw_o=1 at t+2 → WAIT_HI from t+3.
- WAIT_LO exit at cycle u (ch_active_i=0 sampled), rep_cnt≠0 → trig_sw_o=1 at u+1.
- WAIT_LO exit at cycle u, rep_cnt=0 → in GAP from u+1 for gap+1 cycles → next LOAD, or done_o=1 for one cycle with busy_o=0 on the same cycle.
- Watchdog: error declared when ch_active_i stays low for 16 consecutive WAIT_HI cycles.
- seq_idx_o changes on the cycle the FSM enters LOAD.

## Structure
- Shared package: state enum asg_seq_state_t; seg_t struct {ofs, size, step, ncyc, rep, gap}; constant WDOG_LEN=15.
- Table: register array of seg_t (small NSEG; no BRAM inference required).
- No sub-modules; a single FSM module.

## Test plan
- len=2; seg0 {rep=0, gap=3}, seg1 {rep=1, gap=0}; channel model holds ch_active_i high 10 cycles, starting 2 cycles after each trigger → trig_sw_o pulses = 3, set_rst_o pulses = 2, done_o exactly once, err_o=0.
- Start with the channel model silent → err_o=1 after 16 WAIT_HI cycles, set_rst_o pulse, busy_o=0, no done_o.
- loop_i=1, len=3; run through idx 2 → seq_idx_o sequence 0,1,2,0; stop_i mid-WAIT_LO → set_rst_o next cycle, IDLE, no done_o.
- seg_we_i to entry 1 on the same cycle as LOAD of idx 1 → set_ofs_o shows the old value; the next loop pass shows the new value.
- seq_len_i=0 → one segment plays; seq_len_i=NSEG+3 → exactly NSEG segments play.
- dac_rst_i asserted mid-GAP → next cycle all outputs 0, FSM in IDLE; start_i afterwards is accepted normally.
